// File: rtl/mmio_mult_if.sv
// Data-memory bus between the CPU datapath (master) and the multiplier
// responder (slave).
//
// Handshake: there is no valid/ready pair. `we` is a single-cycle store
// strobe, and the responder accepts every cycle, so a store completes at the
// rising edge where `we`=1. Loads are combinational: `rd` follows `a` in the
// same cycle. `sel` tells the top-level read mux to take `rd`.
interface mmio_mult_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        irq;

  modport master (output we, a, wd, input rd, sel, irq);
  modport slave  (input we, a, wd, output rd, sel, irq);
endinterface

// File: rtl/mmio_mult_responder.sv
// Memory-mapped iterative 32x32 shift-add multiplier on the data-memory bus.
// Eight-word window at BASE_ADDR: CTRL, OPA, OPB, RES_LO, RES_HI, COUNT.
// Optional signed mode (CTRL bit2) is built only when MMIO_MULT_SIGNED_EN
// is defined; the default build is unsigned only.
// dbg_state exposes the FSM state for observation.
module mmio_mult_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
  parameter int          ITER      = 32
) (
  input  logic              clk,
  input  logic              rst,
  mmio_mult_if.slave        bus,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   opa, opb;
  logic [31:0]   res_lo, res_hi;
  logic [31:0]   mcand, acc, mplier;
  logic [CW-1:0] count;
  logic          busy, done;
  logic          mode, neg;

  logic [2:0]    off;
  logic          wr, ctrl_wr, start_wr, clr_wr;
  logic [31:0]   mag_a, mag_b;
  logic [32:0]   sum;
  logic [63:0]   prod_next, prod_final;
  logic [31:0]   rdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.a[1:0];

  assign bus.sel  = (bus.a[31:5] == BASE_ADDR[31:5]);
  assign off      = bus.a[4:2];
  assign wr       = bus.we && bus.sel;
  assign ctrl_wr  = wr && (off == 3'd0);
  assign start_wr = ctrl_wr && bus.wd[0];
  assign clr_wr   = ctrl_wr && bus.wd[1];

`ifdef MMIO_MULT_SIGNED_EN
  // Signed mode is taken from the start write itself, so CTRL=0x5 both
  // selects signed and starts in one store.
  assign mag_a = (bus.wd[2] && opa[31]) ? (~opa + 32'd1) : opa;
  assign mag_b = (bus.wd[2] && opb[31]) ? (~opb + 32'd1) : opb;
`else
  assign mode  = 1'b0;
  assign neg   = 1'b0;
  assign mag_a = opa;
  assign mag_b = opb;
`endif

  // One shift-add step: 33-bit add keeps the carry, which shifts into bit 63.
  always_comb begin
    sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    prod_next  = {sum, mplier[31:1]};
    prod_final = neg ? (~prod_next + 64'd1) : prod_next;
  end

  // Control FSM, operand registers and iterative datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef MMIO_MULT_SIGNED_EN
      mode   <= 1'b0;
      neg    <= 1'b0;
`endif
    end else begin
      // Operand registers stay writable while busy; the run uses its snapshot.
      if (wr && off == 3'd1) opa <= bus.wd;
      if (wr && off == 3'd2) opb <= bus.wd;
`ifdef MMIO_MULT_SIGNED_EN
      if (ctrl_wr) mode <= bus.wd[2];
`endif
      case (state)
        IDLE, DONE: begin
          if (start_wr) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            count  <= CW'(ITER);
            busy   <= 1'b1;
            done   <= 1'b0;
            state  <= RUN;
`ifdef MMIO_MULT_SIGNED_EN
            neg    <= bus.wd[2] && (opa[31] ^ opb[31]);
`endif
          end else if (clr_wr) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // Start and done-clear writes are ignored here.
          acc    <= prod_next[63:32];
          mplier <= prod_next[31:0];
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            res_hi <= prod_final[63:32];
            res_lo <= prod_final[31:0];
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register read mux; zero outside the window and for unused offsets.
  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = {29'd0, mode, done, busy};
      3'd1:    rdata = opa;
      3'd2:    rdata = opb;
      3'd3:    rdata = res_lo;
      3'd4:    rdata = res_hi;
      3'd5:    rdata = 32'(count);
      default: rdata = '0;
    endcase
  end

  assign bus.rd    = bus.sel ? rdata : 32'd0;
  assign bus.irq   = done;
  assign dbg_state = state;

endmodule

// File: tb/tb_mmio_mult_responder.sv
// Self-checking bench for mmio_mult_responder: directed steps plus random
// operands, checked against a plain-arithmetic product model and an
// expected-result queue.
module tb_mmio_mult_responder;

  localparam logic [31:0] BASE   = 32'h0000_0800;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_OPA  = BASE + 32'd4;
  localparam logic [31:0] A_OPB  = BASE + 32'd8;
  localparam logic [31:0] A_RLO  = BASE + 32'd12;
  localparam logic [31:0] A_RHI  = BASE + 32'd16;
  localparam logic [31:0] A_CNT  = BASE + 32'd20;
  localparam logic [31:0] A_R6   = BASE + 32'd24;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  mmio_mult_if bus();

  mmio_mult_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_opa, m_opb;
  logic        m_mode, m_busy, m_done;
  logic [63:0] m_res;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_opa = '0; m_opb = '0; m_mode = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_res = '0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
    if (addr[31:5] == BASE[31:5]) begin
      case (addr[4:2])
        3'd1: m_opa = data;
        3'd2: m_opb = data;
        3'd0: begin
`ifdef MMIO_MULT_SIGNED_EN
          m_mode = data[2];
`endif
          if (!m_busy) begin
            if (data[0]) begin
              exp_q.push_back(ref_mul(m_opa, m_opb, m_mode));
              m_busy = 1'b1;
              m_done = 1'b0;
            end else if (data[1]) begin
              m_done = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.a  = addr;
    bus.wd = data;
    bus.we = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    model_write(addr, data);
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] d);
    bus.a = addr;
    #1;
    d = bus.rd;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    @(negedge clk);
    peek(addr, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_result(input string tag);
    logic [31:0] lo, hi;
    logic [63:0] e;
    @(negedge clk);
    peek(A_RLO, lo);
    peek(A_RHI, hi);
    check({tag, "_expq"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_res"}, {hi, lo}, e);
      m_res  = e;
      m_busy = 1'b0;
      m_done = 1'b1;
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      peek(A_CTRL, s);
      n++;
    end while (!s[1] && n < 40);
    check({tag, "_done_seen"}, 64'(s[1]), 64'd1);
    check_result(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, c, s;
    logic [31:0] ra, rb, rc;

    bus.we = 1'b0;
    bus.a  = '0;
    bus.wd = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and decode
    bus_read(A_CTRL, d); check("rst_ctrl", d, 64'd0);
    bus_read(A_OPA, d);  check("rst_opa", d, 64'd0);
    bus_read(A_RHI, d);  check("rst_res_hi", d, 64'd0);
    bus_read(A_R6, d);   check("rst_off6", d, 64'd0);
    bus_read(32'h0000_0000, d);
    check("sel_outside", 64'(bus.sel), 64'd0);
    check("rd_outside", d, 64'd0);
    check("rst_irq", 64'(bus.irq), 64'd0);
    bus_read(A_CTRL, d);
    check("sel_inside", 64'(bus.sel), 64'd1);

    // 3 x 5 with per-cycle COUNT/busy/done trace
    bus_write(A_OPA, 32'd3);
    bus_write(A_OPB, 32'd5);
    bus_write(A_CTRL, 32'h1);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      peek(A_CNT, c);
      peek(A_CTRL, s);
      check($sformatf("count_k%0d", k), c, 64'(32 - k));
      check($sformatf("busy_k%0d", k), 64'(s[0]), 64'(k < 32));
      check($sformatf("done_k%0d", k), 64'(s[1]), 64'(k == 32));
    end
    check("irq_3x5", 64'(bus.irq), 64'd1);
    check_result("mul_3x5");
    bus_read(A_RLO, d); check("res_lo_15", d, 64'h0000_000F);

    // All-ones operands
    bus_write(A_OPA, 32'hFFFF_FFFF);
    bus_write(A_OPB, 32'hFFFF_FFFF);
    bus_write(A_CTRL, 32'h1);
    wait_done("mul_ones");
    bus_read(A_RHI, d); check("ones_hi", d, 64'hFFFF_FFFE);
    bus_read(A_RLO, d); check("ones_lo", d, 64'h0000_0001);

    // Done clear keeps results
    bus_write(A_CTRL, 32'h2);
    bus_read(A_CTRL, d);
    check("clr_done", 64'(d[1]), 64'(m_done));
    check("clr_irq", 64'(bus.irq), 64'd0);
    bus_read(A_RLO, d); check("clr_res_kept", d, 64'(m_res[31:0]));

    // Start + clear together from DONE: start wins
    bus_write(A_OPA, 32'd6);
    bus_write(A_OPB, 32'd7);
    bus_write(A_CTRL, 32'h1);
    wait_done("mul_6x7");
    bus_write(A_CTRL, 32'h3);
    bus_read(A_CTRL, d);
    check("w3_busy", 64'(d[0]), 64'd1);
    check("w3_done", 64'(d[1]), 64'd0);
    wait_done("mul_w3");

    // Writes to RO offsets, unused offsets and outside the window
    bus_write(A_RLO, 32'hDEAD_BEEF);
    bus_read(A_RLO, d); check("ro_res_lo", d, 64'(m_res[31:0]));
    bus_write(A_CNT, 32'd17);
    bus_read(A_CNT, d); check("ro_count", d, 64'd0);
    bus_write(A_R6, 32'h1234_5678);
    bus_read(A_R6, d); check("off6_write", d, 64'd0);
    bus_write(32'h0000_0004, 32'hCAFE_F00D);
    bus_read(A_OPA, d); check("outside_write", d, 64'(m_opa));

    // Start/clear/operand writes while busy do not disturb the run
    ra = $urandom; rb = $urandom;
    bus_write(A_OPA, ra);
    bus_write(A_OPB, rb);
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    bus_write(A_OPA, $urandom);
    bus_write(A_OPB, $urandom);
    bus_write(A_CTRL, 32'h3);
    bus_read(A_OPA, d); check("busy_opa_upd", d, 64'(m_opa));
    bus_read(A_RLO, d); check("busy_res_hold", d, 64'(m_res[31:0]));
    wait_done("mul_busy_writes");

    // Abort by reset mid-run; the first product must never appear
    bus_write(A_OPA, 32'd7);
    bus_write(A_OPB, 32'd9);
    bus_write(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    bus_write(A_OPA, 32'd2);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_OPA, d); check("abort_opa2", d, 64'd2);
    repeat (11) @(negedge clk);
    do_reset();
    bus_read(A_RLO, d);  check("abort_res_lo", d, 64'd0);
    bus_read(A_RHI, d);  check("abort_res_hi", d, 64'd0);
    bus_read(A_CTRL, d); check("abort_ctrl", d, 64'd0);
    bus_read(A_CNT, d);  check("abort_count", d, 64'd0);
    bus_read(A_OPA, d);  check("abort_opa", d, 64'd0);
    repeat (40) @(negedge clk);
    bus_read(A_RLO, d);  check("abort_no_late_res", d, 64'd0);
    bus_write(A_OPA, 32'd2);
    bus_write(A_OPB, 32'd4);
    bus_write(A_CTRL, 32'h1);
    wait_done("mul_2x4");
    bus_read(A_RLO, d); check("res_lo_8", d, 64'd8);

    // Random operands, random bit2 (ignored unless signed mode is built)
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = (i == 0) ? 32'd0 : $urandom;
      rc = {29'd0, 1'($urandom_range(0, 1)), 2'b01};
      bus_write(A_OPA, ra);
      bus_write(A_OPB, rb);
      bus_write(A_CTRL, rc);
      wait_done($sformatf("rand%0d", i));
      bus_read(A_CTRL, d);
      check($sformatf("rand%0d_mode", i), 64'(d[2]), 64'(m_mode));
    end

    // -3 x 5: signed when built with signed mode, unsigned otherwise
    bus_write(A_CTRL, 32'h4);
    bus_write(A_OPA, 32'hFFFF_FFFD);
    bus_write(A_OPB, 32'd5);
    bus_write(A_CTRL, 32'h5);
    wait_done("mul_neg3x5");
    bus_read(A_RLO, d); check("neg3_lo", d, 64'hFFFF_FFF1);
    bus_read(A_RHI, d);
`ifdef MMIO_MULT_SIGNED_EN
    check("neg3_hi", d, 64'hFFFF_FFFF);
`else
    check("neg3_hi", d, 64'h0000_0004);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
